// File: rtl/id_pkg.sv
// Shared constants, saturation helpers and debug enum for the ID counter.
package id_pkg;

   // Legal nominal divide range
   localparam int unsigned N_DIV_MIN = 3;
   localparam int unsigned N_DIV_MAX = 255;

   // Divider decision taken in a given cycle
   typedef enum logic [1:0] {NORMAL, ADVANCE, RETARD} div_mode_t;

   // Largest value a signed register of width w can hold
   function automatic int pend_max(input int unsigned w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Smallest value a signed register of width w can hold
   function automatic int pend_min(input int unsigned w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/id_edge_det.sv
// One-bit rising-edge detector; a level held high yields a single pulse.
module id_edge_det
   import id_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic q;

   // Previous-cycle copy of the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/id_counter_n.sv
// Increment/decrement counter: divides IDclock by N_DIV and pulls the
// recovered clock phase by one IDclock cycle per queued correction.
module id_counter_n
   import id_pkg::*;
#(
   parameter int unsigned N_DIV  = 4,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned PEND_W = 3
) (
   input  logic              IDclock,
   input  logic              reset,
   input  logic              enable,
   input  logic              inc,
   input  logic              dec,
   output logic              IDout,
   output logic              tick,
   output logic [PEND_W-1:0] pending,
   output logic              adv_pulse,
   output logic              ret_pulse,
   output logic              sat_pulse
);

   localparam logic [CNT_W-1:0] CntAdv   = CNT_W'(N_DIV - 2);
   localparam logic [CNT_W-1:0] CntLast  = CNT_W'(N_DIV - 1);
   localparam logic [CNT_W-1:0] CntExtra = CNT_W'(N_DIV);
   localparam logic [CNT_W-1:0] CntHalf  = CNT_W'(N_DIV / 2);

   localparam logic signed [PEND_W:0] PendMax = (PEND_W + 1)'(pend_max(PEND_W));
   localparam logic signed [PEND_W:0] PendMin = (PEND_W + 1)'(pend_min(PEND_W));
   localparam logic signed [PEND_W:0] PendOne = (PEND_W + 1)'(1);

   logic                     inc_edge, dec_edge;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [PEND_W-1:0] pend_q, pend_d;
   logic signed [PEND_W:0]   pend_sum;
   logic                     pend_pos, pend_neg;
   logic                     sat_d;
   div_mode_t                mode;

   id_edge_det u_inc_edge (
      .clk   (IDclock),
      .rst_n (reset),
      .d     (inc),
      .rise  (inc_edge)
   );

   id_edge_det u_dec_edge (
      .clk   (IDclock),
      .rst_n (reset),
      .d     (dec),
      .rise  (dec_edge)
   );

   assign pend_neg = pend_q[PEND_W-1];
   assign pend_pos = !pend_neg && (pend_q != '0);

   // Correction decision and divider next count; advance ends the period one
   // cycle early, retard detours through the extra count N_DIV
   always_comb begin
      mode = NORMAL;
      if (cnt_q == CntAdv && pend_pos)       mode = ADVANCE;
      else if (cnt_q == CntLast && pend_neg) mode = RETARD;
      unique case (mode)
         ADVANCE: cnt_d = '0;
         RETARD:  cnt_d = CntExtra;
         default: cnt_d = (cnt_q >= CntLast) ? '0 : cnt_q + 1'b1;
      endcase
   end

   // Pending next value: edges in, corrections out, saturated to PEND_W range
   always_comb begin
      pend_sum = (PEND_W + 1)'(pend_q);
      if (inc_edge) pend_sum = pend_sum + PendOne;
      if (dec_edge) pend_sum = pend_sum - PendOne;
      if (enable && mode == ADVANCE) pend_sum = pend_sum - PendOne;
      if (enable && mode == RETARD)  pend_sum = pend_sum + PendOne;
      sat_d  = 1'b0;
      pend_d = pend_sum[PEND_W-1:0];
      // Consumption only moves toward zero, so any clip is due to an edge
      if (pend_sum > PendMax) begin
         pend_d = PendMax[PEND_W-1:0];
         sat_d  = 1'b1;
      end else if (pend_sum < PendMin) begin
         pend_d = PendMin[PEND_W-1:0];
         sat_d  = 1'b1;
      end
   end

   // State registers; divider and its outputs freeze while enable is low
   always_ff @(posedge IDclock or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         pend_q    <= '0;
         IDout     <= 1'b0;
         tick      <= 1'b0;
         adv_pulse <= 1'b0;
         ret_pulse <= 1'b0;
         sat_pulse <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         sat_pulse <= sat_d;
         adv_pulse <= enable && (mode == ADVANCE);
         ret_pulse <= enable && (mode == RETARD);
         if (enable) begin
            cnt_q <= cnt_d;
            IDout <= (cnt_d < CntHalf);
            tick  <= (cnt_d == '0);
         end
      end
   end

   assign pending = pend_q;

endmodule

// File: tb/tb_id_counter_n.sv
// Randomised and directed bench for id_counter_n against a period-level model.
module tb_id_counter_n;

   localparam int N  = 4;
   localparam int PW = 3;
   localparam int PMAX = (1 << (PW - 1)) - 1;
   localparam int PMIN = -(1 << (PW - 1));

   logic clk = 1'b0;
   logic reset, enable, inc, dec;
   logic IDout, tick, adv_pulse, ret_pulse, sat_pulse;
   logic [PW-1:0] pending;

   int checks = 0;
   int errors = 0;

   // Model state: position within the current output period
   int m_pos, m_pend;
   bit m_inc_prev, m_dec_prev;
   bit m_idout, m_tick, m_adv, m_ret, m_sat;

   // Observation counters
   int cyc = 0, last_tick = 0, last_period = 0;
   int min_period = 999, max_period = 0;
   bit have_tick = 0;
   int adv_cnt = 0, ret_cnt = 0, sat_cnt = 0;

   always #5 clk = ~clk;

   id_counter_n #(
      .N_DIV  (N),
      .CNT_W  (8),
      .PEND_W (PW)
   ) dut (
      .IDclock   (clk),
      .reset     (reset),
      .enable    (enable),
      .inc       (inc),
      .dec       (dec),
      .IDout     (IDout),
      .tick      (tick),
      .pending   (pending),
      .adv_pulse (adv_pulse),
      .ret_pulse (ret_pulse),
      .sat_pulse (sat_pulse)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_pend = 0; m_inc_prev = 0; m_dec_prev = 0;
      m_idout = 0; m_tick = 0; m_adv = 0; m_ret = 0; m_sat = 0;
      have_tick = 0;
   endtask

   // One IDclock cycle of the period rules: period N normally, N-1 when an
   // advance is owed at position N-2, N+1 when a retard is owed at N-1
   task automatic model_step(input bit en, input bit i, input bit d);
      int ie, de, consume, s;
      ie = (i && !m_inc_prev) ? 1 : 0;
      de = (d && !m_dec_prev) ? 1 : 0;
      consume = 0;
      m_adv = 0;
      m_ret = 0;
      if (en) begin
         if (m_pos == N - 2 && m_pend > 0) begin
            m_adv = 1; consume = 1; m_pos = 0;
         end else if (m_pos == N - 1 && m_pend < 0) begin
            m_ret = 1; consume = -1; m_pos = N;
         end else if (m_pos >= N - 1) begin
            m_pos = 0;
         end else begin
            m_pos = m_pos + 1;
         end
         m_idout = (m_pos < N / 2);
         m_tick  = (m_pos == 0);
      end
      s = m_pend + ie - de - consume;
      m_sat = (s > PMAX) || (s < PMIN);
      if (s > PMAX) s = PMAX;
      if (s < PMIN) s = PMIN;
      m_pend = s;
      m_inc_prev = i;
      m_dec_prev = d;
   endtask

   task automatic step(input bit en, input bit i, input bit d);
      @(negedge clk);
      enable = en; inc = i; dec = d;
      @(posedge clk);
      model_step(en, i, d);
      #1;
      cyc++;
      check("idout", int'(IDout), int'(m_idout));
      check("tick", int'(tick), int'(m_tick));
      check("pending", int'($signed(pending)), m_pend);
      check("adv_pulse", int'(adv_pulse), int'(m_adv));
      check("ret_pulse", int'(ret_pulse), int'(m_ret));
      check("sat_pulse", int'(sat_pulse), int'(m_sat));
      if (adv_pulse) adv_cnt++;
      if (ret_pulse) ret_cnt++;
      if (sat_pulse) sat_cnt++;
      if (en && tick) begin
         if (have_tick) begin
            last_period = cyc - last_tick;
            if (last_period < min_period) min_period = last_period;
            if (last_period > max_period) max_period = last_period;
         end
         have_tick = 1;
         last_tick = cyc;
      end
   endtask

   task automatic clear_stats();
      min_period = 999; max_period = 0;
      adv_cnt = 0; ret_cnt = 0; sat_cnt = 0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; inc = 1'b0; dec = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_idout", int'(IDout), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_pending", int'($signed(pending)), 0);
      check("rst_pulses", int'({adv_pulse, ret_pulse, sat_pulse}), 0);
      reset = 1'b1;

      // Free run
      step(1, 0, 0);
      check("first_idout", int'(IDout), 1);
      repeat (5) step(1, 0, 0);
      clear_stats();
      repeat (12) step(1, 0, 0);
      check("free_min_period", min_period, 4);
      check("free_max_period", max_period, 4);

      // inc held for 10 cycles: exactly one advance
      clear_stats();
      step(1, 1, 0);
      check("inc_pend_one", int'($signed(pending)), 1);
      repeat (9) step(1, 1, 0);
      repeat (8) step(1, 0, 0);
      check("inc_adv_count", adv_cnt, 1);
      check("inc_min_period", min_period, 3);
      check("inc_pend_zero", int'($signed(pending)), 0);

      // Single dec edge: one 5-cycle period then back to 4
      clear_stats();
      step(1, 0, 1);
      check("dec_pend_neg", int'($signed(pending)), -1);
      repeat (14) step(1, 0, 0);
      check("dec_ret_count", ret_cnt, 1);
      check("dec_max_period", max_period, 5);
      check("dec_last_period", last_period, 4);

      // Five inc edges while disabled: saturate at the top limit
      clear_stats();
      repeat (5) begin
         step(0, 1, 0);
         step(0, 0, 0);
      end
      check("sat_pend", int'($signed(pending)), PMAX);
      check("sat_count", sat_cnt, 2);
      repeat (24) step(1, 0, 0);
      check("sat_adv_count", adv_cnt, PMAX);
      check("sat_drained", int'($signed(pending)), 0);

      // Simultaneous inc and dec edges cancel
      clear_stats();
      step(1, 1, 1);
      check("both_pend", int'($signed(pending)), 0);
      check("both_sat", int'(sat_pulse), 0);
      repeat (12) step(1, 0, 0);
      check("both_max_period", max_period, 4);

      // Randomised traffic
      repeat (400) step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 2) == 0);

      // Drain, queue two advances while frozen, then reset mid-period
      repeat (40) step(1, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      check("pre_reset_pend", int'($signed(pending)), 2);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("async_idout", int'(IDout), 0);
      check("async_tick", int'(tick), 0);
      check("async_pending", int'($signed(pending)), 0);
      check("async_pulses", int'({adv_pulse, ret_pulse, sat_pulse}), 0);
      @(negedge clk);
      inc = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
      step(1, 0, 0);
      check("post_reset_idout", int'(IDout), 1);
      repeat (12) step(1, 0, 0);
      check("post_reset_adv", adv_cnt, 0);
      check("post_reset_period", max_period, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_counter_n.md
Name: id_counter_n

Overview:
- Parametrised increment/decrement (ID) counter for the DPLL clock-recovery path of the APB-to-SPI-NOR flash controller.
- Divides IDclock by N_DIV to produce a recovered clock, IDout.
- Rising edges on inc/dec are queued as signed phase corrections in a pending register.
- Each output period can be shortened (advance) or lengthened (retard) by one IDclock cycle to pull phase.

Parameters:
- N_DIV, default 4: nominal IDout period in IDclock cycles. Legal range 3..255.
- CNT_W, default 8: divider counter width. Must satisfy 2^CNT_W > N_DIV.
- PEND_W, default 3: width of the signed pending-correction register. Range is -2^(PEND_W-1) .. 2^(PEND_W-1)-1.

Ports:
- IDclock  in  1  sole clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; release is synchronous to IDclock.
- enable  in  1  divider run enable. Edge capture and queuing continue while low.
- inc  in  1  level request to advance phase. Acts on its rising edge.
- dec  in  1  level request to retard phase. Acts on its rising edge.
- IDout  out  1  registered recovered clock.
- tick  out  1  one-cycle pulse in the cycle where cnt==0.
- pending  out  PEND_W  signed queued corrections: positive = advances owed, negative = retards owed.
- adv_pulse  out  1  one cycle; a shortened period was applied.
- ret_pulse  out  1  one cycle; a lengthened period was applied.
- sat_pulse  out  1  one cycle; an edge was dropped because pending was saturated.

Behaviour:
- Reset values: cnt=0, pending=0, inc_q=dec_q=0, IDout=0, tick=0, adv_pulse=0, ret_pulse=0, sat_pulse=0.
- Edge detect:
  - inc_edge = inc & ~inc_q; dec_edge = dec & ~dec_q. inc_q/dec_q update every cycle.
  - A level held high yields exactly one edge.
  - Edge to pending update latency is 1 cycle.
- Divider states, with enable=1:
  - NORMAL: cnt increments. cnt==N_DIV-1 -> cnt=0.
  - ADVANCE: at cnt==N_DIV-2 with pending>0 -> cnt=0. Period becomes N_DIV-1. adv_pulse=1, consume -1.
  - RETARD: at cnt==N_DIV-1 with pending<0 -> cnt=N_DIV (extra state). Period becomes N_DIV+1. ret_pulse=1, consume +1.
  - From cnt==N_DIV -> cnt=0.
  - At most one correction per period. Decisions use the registered pending value.
- Pending update:
  - pending_next = pending + inc_edge - dec_edge - consume_delta.
  - Computed at PEND_W+1 bits, then saturated to the PEND_W range.
  - If saturation clips a non-zero edge contribution: sat_pulse=1 and pending holds at the limit.
  - inc_edge and dec_edge in the same cycle cancel; no sat_pulse.
  - A correction consumed in the same cycle as a new edge: both deltas apply.
- Output:
  - IDout registered: IDout <= (cnt_next < N_DIV/2), integer division.
  - tick <= (cnt_next==0).
  - Both update only when enable=1; otherwise they hold.
  - The first enabled cycle after reset release gives IDout=1.
- enable=0: cnt, IDout and tick hold. No corrections are consumed; adv_pulse and ret_pulse stay 0.
- Reset mid-period: all state clears immediately, including pending. Queued corrections are discarded.
- Glitch-free: IDout comes straight from a flop, with no combinational use of IDclock.

Decomposition:
- Shared package id_pkg holds:
  - constants for the legal N_DIV range;
  - a localparam function for the saturation limits;
  - an enum div_mode_t {NORMAL, ADVANCE, RETARD} used for debug/coverage.
- One natural sub-module: id_edge_det, a one-bit rising-edge detector with asynchronous active-low reset. Instantiate it twice, for inc and dec.
- Divider and pending logic stay in the top module.

Test Plan:
- Free run, N_DIV=4, enable=1, no inc/dec:
  - IDout = 1,1,0,0 repeating.
  - tick every 4 cycles; pending stays 0.
- Single inc pulse held 10 cycles:
  - pending=1 one cycle after the edge.
  - Next period lasts 3 cycles with adv_pulse=1; pending returns to 0.
  - Only one advance occurs despite the held level.
- Single dec edge:
  - pending=-1.
  - Next period lasts 5 cycles (cnt reaches 4) with ret_pulse=1; pending=0.
  - Following period is 4 cycles.
- Five inc edges before any wrap, PEND_W=3, enable=0:
  - pending saturates at 3; sat_pulse on edges 4 and 5.
  - After enable=1: three consecutive 3-cycle periods, then 4-cycle periods.
- inc and dec rising in the same cycle:
  - pending unchanged (0), no sat_pulse.
  - Periods stay 4 cycles.
- reset asserted asynchronously mid-period with pending=2:
  - All outputs 0 immediately.
  - After release: pending=0 and free-run sequence 1,1,0,0 resumes from cnt=0.
